// File: rtl/tdc_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_chain_ctrl
//
// Measurement sequencer for a carry-chain TDC delay line. One measurement:
//   IDLE   -> wait for meas_req, clear the coarse counter
//   RUN    -> chain_start held high, coarse counter runs until hit (or saturates)
//   ENCODE -> snapshot of the thermometer taps is turned into a binary fine code
//   HOLD   -> result presented on the res_* port until the host accepts it
//   FLUSH  -> chain_start low, wait for the chain to drain back to all-zero
//
// Result handshake: res_valid rises in HOLD and every res_* output is frozen
// while res_valid=1. A transfer happens on a clock edge where res_valid=1 and
// res_ready=1. res_valid drops on the following cycle. res_ready has no effect
// while res_valid=0.
//
// Build option: define TDC_CTRL_POPCOUNT_EN to make the fine code the
// population count of the snapshot, which tolerates bubbles. Without it, the
// fine code is the index of the lowest zero tap. err_bubble is computed the same
// way in both builds.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   meas_req       start request, only looked at in IDLE
//   hit            stop event, already synchronous to clk
//   chain_taps     registered thermometer taps, bit 0 nearest the start
//   chain_start    drives the chain start/cin input
//   busy           high in every state except IDLE
//   res_valid      result valid
//   res_ready      result accepted
//   res_coarse     clock periods from launch to hit (all ones on timeout)
//   res_fine       encoded fine code
//   res_timeout    no hit before the coarse counter saturated
//   err_bubble     snapshot was not a clean thermometer code
//   err_flush      chain failed to clear within FLUSH_MAX cycles (sticky)
//   dbg_state      current FSM state (IDLE=0 RUN=1 ENCODE=2 HOLD=3 FLUSH=4)
// -----------------------------------------------------------------------------
module tdc_chain_ctrl #(
    parameter int LENGTH    = 8,
    parameter int COARSE_W  = 8,
    parameter int FINE_W    = 4,
    parameter int FLUSH_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                meas_req,
    input  logic                hit,
    input  logic [LENGTH-1:0]   chain_taps,
    output logic                chain_start,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [COARSE_W-1:0] res_coarse,
    output logic [FINE_W-1:0]   res_fine,
    output logic                res_timeout,
    output logic                err_bubble,
    output logic                err_flush,
    output logic [2:0]          dbg_state
);

    localparam int FLUSH_W = $clog2(FLUSH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_ENCODE = 3'd2,
        S_HOLD   = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t              state;
    logic [COARSE_W-1:0] coarse;
    logic [LENGTH-1:0]   snap_taps;
    logic                snap_timeout;
    logic [FLUSH_W-1:0]  flush_cnt;

    assign dbg_state = state;

    // Snapshot encoder. lz_fine is the index of the lowest zero tap (LENGTH
    // when every tap is one); any one above that zero marks a bubble.
    logic [FINE_W-1:0] lz_fine;
    logic [FINE_W-1:0] pop_fine;
    logic [FINE_W-1:0] enc_fine;
    logic              enc_bubble;
    logic              seen_zero;

    always_comb begin
        lz_fine    = FINE_W'(LENGTH);
        pop_fine   = '0;
        enc_bubble = 1'b0;
        seen_zero  = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            pop_fine = pop_fine + FINE_W'(snap_taps[i]);
            if (!snap_taps[i] && !seen_zero) begin
                lz_fine   = FINE_W'(i);
                seen_zero = 1'b1;
            end else if (snap_taps[i] && seen_zero) begin
                enc_bubble = 1'b1;
            end
        end
`ifdef TDC_CTRL_POPCOUNT_EN
        enc_fine = pop_fine;
`else
        enc_fine = lz_fine;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            coarse       <= '0;
            snap_taps    <= '0;
            snap_timeout <= 1'b0;
            flush_cnt    <= '0;
            chain_start  <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_coarse   <= '0;
            res_fine     <= '0;
            res_timeout  <= 1'b0;
            err_bubble   <= 1'b0;
            err_flush    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    coarse <= '0;
                    if (meas_req) begin
                        state        <= S_RUN;
                        chain_start  <= 1'b1;
                        busy         <= 1'b1;
                        snap_timeout <= 1'b0;
                    end
                end

                S_RUN: begin
                    // coarse stays frozen from here until ENCODE has used it
                    if (hit) begin
                        snap_taps <= chain_taps;
                        state     <= S_ENCODE;
                    end else if (coarse == '1) begin
                        snap_timeout <= 1'b1;
                        state        <= S_ENCODE;
                    end else begin
                        coarse <= coarse + COARSE_W'(1);
                    end
                end

                S_ENCODE: begin
                    if (snap_timeout) begin
                        res_coarse  <= '1;
                        res_fine    <= '0;
                        res_timeout <= 1'b1;
                        err_bubble  <= 1'b0;
                    end else begin
                        res_coarse  <= coarse;
                        res_fine    <= enc_fine;
                        res_timeout <= 1'b0;
                        err_bubble  <= enc_bubble;
                    end
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end

                S_HOLD: begin
                    // res_valid is always 1 here, so res_ready alone is a transfer
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        chain_start <= 1'b0;
                        flush_cnt   <= '0;
                        state       <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    if (chain_taps == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (flush_cnt == FLUSH_W'(FLUSH_MAX - 1)) begin
                        // FLUSH_MAX cycles seen with taps still set: give up
                        err_flush <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_chain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_chain_ctrl
//
// Directed bench for tdc_chain_ctrl built with COARSE_W=4, so the timeout
// case stays short. Inputs are driven 1 ns after a rising edge. Outputs are
// sampled at that same point, which is away from the active edge. Expected
// results are pushed into exp_q when a hit is issued and popped when the result
// is checked.
// -----------------------------------------------------------------------------
module tb_tdc_chain_ctrl;

    localparam int LENGTH    = 8;
    localparam int COARSE_W  = 4;
    localparam int FINE_W    = 4;
    localparam int FLUSH_MAX = 15;
    localparam int RES_W     = COARSE_W + FINE_W + 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_ENCODE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

`ifdef TDC_CTRL_POPCOUNT_EN
    localparam logic [FINE_W-1:0] BUBBLE_FINE = 4'd5;
    localparam logic [FINE_W-1:0] ZERO_FINE   = 4'd0;
`else
    localparam logic [FINE_W-1:0] BUBBLE_FINE = 4'd4;
    localparam logic [FINE_W-1:0] ZERO_FINE   = 4'd0;
`endif

    // ---------------- clock / reset ----------------
    logic                clk;
    logic                rst_n;
    logic                meas_req;
    logic                hit;
    logic [LENGTH-1:0]   chain_taps;
    logic                chain_start;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [COARSE_W-1:0] res_coarse;
    logic [FINE_W-1:0]   res_fine;
    logic                res_timeout;
    logic                err_bubble;
    logic                err_flush;
    logic [2:0]          dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tdc_chain_ctrl #(
        .LENGTH    (LENGTH),
        .COARSE_W  (COARSE_W),
        .FINE_W    (FINE_W),
        .FLUSH_MAX (FLUSH_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .meas_req    (meas_req),
        .hit         (hit),
        .chain_taps  (chain_taps),
        .chain_start (chain_start),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_coarse  (res_coarse),
        .res_fine    (res_fine),
        .res_timeout (res_timeout),
        .err_bubble  (err_bubble),
        .err_flush   (err_flush),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int               n_checks;
    int               n_fail;
    logic [RES_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] pack_res(input logic [COARSE_W-1:0] c,
                                                  input logic [FINE_W-1:0] f,
                                                  input logic t, input logic b);
        return {c, f, t, b};
    endfunction

    task automatic check_result(input string tag);
        logic [RES_W-1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'({res_coarse, res_fine, res_timeout, err_bubble}), 32'(exp));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input string tag);
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
        check({tag, "_start"}, 32'(chain_start), 32'd1);
        check({tag, "_busy"},  32'(busy),        32'd1);
        check({tag, "_state"}, 32'(dbg_state),   32'(ST_RUN));
    endtask

    // hit after n further RUN cycles; result must appear 2 cycles after hit
    task automatic hit_after(input string tag, input int n, input logic [LENGTH-1:0] taps,
                             input logic [RES_W-1:0] exp);
        repeat (n) tick();
        hit        = 1'b1;
        chain_taps = taps;
        exp_q.push_back(exp);
        tick();
        hit = 1'b0;
        check({tag, "_encode"}, 32'(dbg_state), 32'(ST_ENCODE));
        check({tag, "_lat1"},   32'(res_valid), 32'd0);
        tick();
        check({tag, "_lat2"},   32'(res_valid), 32'd1);
        check_result({tag, "_res"});
    endtask

    task automatic accept(input string tag, input logic [LENGTH-1:0] flush_taps);
        chain_taps = flush_taps;
        res_ready  = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_xfer_valid"}, 32'(res_valid),   32'd0);
        check({tag, "_xfer_start"}, 32'(chain_start), 32'd0);
        check({tag, "_xfer_state"}, 32'(dbg_state),   32'(ST_FLUSH));
        if (flush_taps == '0) begin
            tick();
            check({tag, "_idle_state"}, 32'(dbg_state), 32'(ST_IDLE));
            check({tag, "_idle_busy"},  32'(busy),      32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        logic [RES_W-1:0] held;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        meas_req   = 1'b0;
        hit        = 1'b0;
        chain_taps = '0;
        res_ready  = 1'b0;
        #23;
        check("rst_start", 32'(chain_start), 32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_valid", 32'(res_valid),   32'd0);
        check("rst_eflush",32'(err_flush),   32'd0);
        check("rst_result",32'({res_coarse, res_fine, res_timeout, err_bubble}), 32'd0);
        check("rst_state", 32'(dbg_state),   32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // hit ignored in IDLE
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("idle_hit", 32'(busy), 32'd0);

        // 1: normal measurement, coarse 3, clean code of five ones
        launch("t1");
        hit_after("t1", 3, 8'b0001_1111, pack_res(4'd3, 4'd5, 1'b0, 1'b0));
        accept("t1", 8'h00);
        check("t1_keep", 32'({res_coarse, res_fine}), 32'({4'd3, 4'd5}));

        // all-zero snapshot: fine 0, no bubble
        launch("t1b");
        hit_after("t1b", 5, 8'h00, pack_res(4'd5, ZERO_FINE, 1'b0, 1'b0));
        accept("t1b", 8'h00);

        // 2: bubble snapshot on the first RUN cycle
        launch("t2");
        hit_after("t2", 0, 8'b0010_1111, pack_res(4'd0, BUBBLE_FINE, 1'b0, 1'b1));
        accept("t2", 8'h00);

        // 3: timeout after the 4-bit counter saturates
        launch("t3");
        exp_q.push_back(pack_res(4'hF, 4'd0, 1'b1, 1'b0));
        cnt = 0;
        while (!res_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("t3_latency", 32'(cnt), 32'd17);
        check("t3_start",   32'(chain_start), 32'd1);
        check_result("t3_res");
        accept("t3", 8'h00);

        // 4: backpressure with meas_req/hit toggling
        launch("t4");
        hit_after("t4", 1, 8'h07, pack_res(4'd1, 4'd3, 1'b0, 1'b0));
        held = pack_res(4'd1, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            meas_req   = i[0];
            hit        = ~i[0];
            chain_taps = 8'($urandom_range(0, 255));
            tick();
            check("t4_valid", 32'(res_valid),   32'd1);
            check("t4_busy",  32'(busy),        32'd1);
            check("t4_start", 32'(chain_start), 32'd1);
            check("t4_state", 32'(dbg_state),   32'(ST_HOLD));
            check("t4_res",   32'({res_coarse, res_fine, res_timeout, err_bubble}), 32'(held));
        end
        meas_req = 1'b0;
        hit      = 1'b0;

        // 5: flush failure with the bottom tap stuck high
        accept("t5", 8'h01);
        repeat (14) tick();
        check("t5_eflush_early", 32'(err_flush), 32'd0);
        check("t5_state_early",  32'(dbg_state), 32'(ST_FLUSH));
        tick();
        check("t5_eflush", 32'(err_flush), 32'd1);
        check("t5_state",  32'(dbg_state), 32'(ST_IDLE));
        check("t5_busy",   32'(busy),      32'd0);
        chain_taps = 8'h00;
        launch("t5n");
        hit_after("t5n", 2, 8'hFF, pack_res(4'd2, 4'd8, 1'b0, 1'b0));
        accept("t5n", 8'h00);
        check("t5_sticky", 32'(err_flush), 32'd1);

        // 6: asynchronous reset in the middle of RUN
        launch("t6");
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_start",  32'(chain_start), 32'd0);
        check("t6_busy",   32'(busy),        32'd0);
        check("t6_valid",  32'(res_valid),   32'd0);
        check("t6_eflush", 32'(err_flush),   32'd0);
        #20;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            hit = i[1];
            tick();
            check("t6_no_res",   32'(res_valid),   32'd0);
            check("t6_no_start", 32'(chain_start), 32'd0);
        end
        hit = 1'b0;
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
